// File: rtl/data_mem_arbiter.sv
// data_mem_arbiter: shares one single-port data memory between the CPU (port 0) and a loader (port 1).
// Define ARB_ROUND_ROBIN_EN for round-robin on simultaneous requests; default is fixed port-0 priority.
module data_mem_arbiter #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int MEM_LAT    = 1
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  p0_req,
    input  logic                  p0_we,
    input  logic [ADDR_WIDTH-1:0] p0_addr,
    input  logic [DATA_WIDTH-1:0] p0_wd,
    input  logic [1:0]            p0_bsel,
    output logic                  p0_gnt,
    output logic                  p0_done,
    output logic [DATA_WIDTH-1:0] p0_rd,
    input  logic                  p1_req,
    input  logic                  p1_we,
    input  logic [ADDR_WIDTH-1:0] p1_addr,
    input  logic [DATA_WIDTH-1:0] p1_wd,
    input  logic [1:0]            p1_bsel,
    output logic                  p1_gnt,
    output logic                  p1_done,
    output logic [DATA_WIDTH-1:0] p1_rd,
    output logic                  mem_en,
    output logic                  mem_we,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wd,
    output logic [1:0]            mem_bsel,
    input  logic [DATA_WIDTH-1:0] mem_rd,
    output logic                  busy
);

    if (MEM_LAT < 1 || MEM_LAT > 15) begin : g_lat_check
        $error("data_mem_arbiter: MEM_LAT must be within 1..15");
    end

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

    state_t                state_reg, state_next;
    logic [3:0]            cnt_reg, cnt_next;
    logic                  winner_reg;
    logic                  we_reg;
    logic [ADDR_WIDTH-1:0] addr_reg;
    logic [DATA_WIDTH-1:0] wd_reg;
    logic [1:0]            bsel_reg;

    logic [1:0]            req_vec;
    logic [1:0]            gnt_vec;
    logic [1:0]            done_vec;
    logic                  pick;
    logic                  capture;
    logic [DATA_WIDTH-1:0] rd_bus [2];

    assign req_vec = {p1_req, p0_req};

`ifdef ARB_ROUND_ROBIN_EN
    logic last_grant_reg;

    // On a tie the port that did not win last time goes first.
    assign pick = (p0_req && p1_req) ? ~last_grant_reg : p1_req;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant_reg <= 1'b1;
        end else if (|gnt_vec) begin
            last_grant_reg <= pick;
        end
    end
`else
    assign pick = ~p0_req;
`endif

    always_comb begin
        state_next = state_reg;
        cnt_next   = cnt_reg;
        gnt_vec    = 2'b00;
        capture    = 1'b0;
        case (state_reg)
            IDLE: begin
                // Grant is combinational, so it must be masked while reset is held.
                if (|req_vec && !rst) begin
                    gnt_vec[pick] = 1'b1;
                    state_next    = ISSUE;
                end
            end
            ISSUE: begin
                cnt_next   = LAT_LOAD;
                state_next = WAIT;
            end
            WAIT: begin
                if (cnt_reg == 4'd0) begin
                    capture    = 1'b1;
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg - 4'd1;
                end
            end
            RESP: begin
                state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg  <= IDLE;
            cnt_reg    <= 4'd0;
            winner_reg <= 1'b0;
            we_reg     <= 1'b0;
            addr_reg   <= '0;
            wd_reg     <= '0;
            bsel_reg   <= 2'b00;
        end else begin
            state_reg <= state_next;
            cnt_reg   <= cnt_next;
            if (|gnt_vec) begin
                winner_reg <= pick;
                we_reg     <= pick ? p1_we   : p0_we;
                addr_reg   <= pick ? p1_addr : p0_addr;
                wd_reg     <= pick ? p1_wd   : p0_wd;
                bsel_reg   <= pick ? p1_bsel : p0_bsel;
            end
        end
    end

    // Each port owns its read register; only the winner's copy ever moves.
    genvar gi;
    for (gi = 0; gi < 2; gi++) begin : g_port
        logic [DATA_WIDTH-1:0] rd_reg;

        always_ff @(posedge clk or posedge rst) begin
            if (rst) begin
                rd_reg <= '0;
            end else if (capture && !we_reg && (winner_reg == 1'(gi))) begin
                rd_reg <= mem_rd;
            end
        end

        assign rd_bus[gi]   = rd_reg;
        assign done_vec[gi] = (state_reg == RESP) && (winner_reg == 1'(gi));
    end

    assign p0_gnt   = gnt_vec[0];
    assign p1_gnt   = gnt_vec[1];
    assign p0_done  = done_vec[0];
    assign p1_done  = done_vec[1];
    assign p0_rd    = rd_bus[0];
    assign p1_rd    = rd_bus[1];

    assign mem_en   = (state_reg == ISSUE);
    assign mem_we   = (state_reg == ISSUE) && we_reg;
    assign mem_addr = addr_reg;
    assign mem_wd   = wd_reg;
    assign mem_bsel = bsel_reg;
    assign busy     = (state_reg != IDLE);

endmodule
